// File: rtl/spram_stream_reader_pkg.sv
// +----------------------------------------------------------------------------+
// | spram_stream_reader_pkg                                                    |
// | Shared SPRAM geometry, stream FSM state encoding and address helper.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package spram_stream_reader_pkg;

  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DATA_W = 16;
  localparam int SPRAM_LEN_W  = 15;

  // Shared with the capture-side writer block.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;

  // Word address of a transfer offset; wraps naturally at the top of the RAM.
  function automatic logic [SPRAM_ADDR_W-1:0] word_addr(
    input logic [SPRAM_ADDR_W-1:0] base,
    input logic [SPRAM_ADDR_W-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spram_stream_reader_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO with registered head; DEPTH must be a power of two >= 2. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/spram_stream_reader.sv
// +----------------------------------------------------------------------------+
// | spram_stream_reader                                                        |
// | Streams LENGTH words from the shared SPRAM, yielding to the writer port.   |
// | Optional abort input enabled by defining SPRAM_READER_ABORT_EN.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module spram_stream_reader
  import spram_stream_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SPRAM_READER_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  input  logic [SPRAM_ADDR_W-1:0] base_addr,
  input  logic [SPRAM_LEN_W-1:0]  length,
  output logic                    busy,
  output logic                    done,
  input  logic                    ram_wr_busy,
  output logic                    ram_rd_en,
  output logic [SPRAM_ADDR_W-1:0] ram_rd_addr,
  input  logic [SPRAM_DATA_W-1:0] ram_rd_data,
  output logic [SPRAM_DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  stream_state_t           r_state;
  stream_state_t           w_next_state;
  logic [SPRAM_ADDR_W-1:0] r_base;
  logic [SPRAM_LEN_W-1:0]  r_length;
  logic [SPRAM_LEN_W-1:0]  r_issued;
  logic [SPRAM_LEN_W-1:0]  r_accepted;
  logic                    r_inflight;
  logic                    r_aborted;

  logic [CW-1:0]           w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [CW:0]             w_credit_used;
  logic                    w_abort;
  logic                    w_start_accept;
  logic                    w_accept;
  logic                    w_all_issued;
  logic                    w_finished;

`ifdef SPRAM_READER_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_start_accept = start && (r_state == ST_IDLE);
  assign w_accept       = out_valid && out_ready;
  assign w_all_issued   = (r_issued == r_length);
  assign w_finished     = r_aborted || (r_accepted == r_length);
  // Words in the FIFO plus a read still returning from the RAM.
  assign w_credit_used  = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};

  always_comb begin
    w_next_state = r_state;
    ram_rd_en    = 1'b0;
    done         = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (length == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        ram_rd_en = !ram_wr_busy && !w_all_issued && !w_abort &&
                    (w_credit_used < DEPTH_C);
        if (w_abort || w_all_issued) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        done = w_finished;
        if (w_finished) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_length   <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= ram_rd_en;
      if (w_start_accept) begin
        r_base     <= base_addr;
        r_length   <= length;
        r_issued   <= '0;
        r_accepted <= '0;
        r_aborted  <= 1'b0;
      end else begin
        if (ram_rd_en) r_issued   <= r_issued + 1'b1;
        if (w_accept)  r_accepted <= r_accepted + 1'b1;
        if (w_abort)   r_aborted  <= 1'b1;
      end
    end
  end

  assign ram_rd_addr = word_addr(r_base, r_issued[SPRAM_ADDR_W-1:0]);

  // Abort flushes queued words and drops the read returning this cycle.
  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SPRAM_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_abort),
    .push      (r_inflight),
    .push_data (ram_rd_data),
    .pop       (w_accept),
    .head_data (out_data),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign out_valid = !w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_spram_stream_reader.sv
// +----------------------------------------------------------------------------+
// | tb_spram_stream_reader                                                     |
// | Self-checking bench: SPRAM model, queue-based reference, vector table.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spram_stream_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] length;
  logic        busy;
  logic        done;
  logic        ram_wr_busy;
  logic        ram_rd_en;
  logic [13:0] ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef SPRAM_READER_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  spram_stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef SPRAM_READER_ABORT_EN
    .abort       (abort),
`endif
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_wr_busy (ram_wr_busy),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  function automatic logic [15:0] mem_word(input logic [13:0] a);
    return {a[5:0], a[13:4]} ^ 16'hC35A;
  endfunction

  // SPRAM: data appears one cycle after the read is issued.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem_word(ram_rd_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered addresses still to be read / words still to arrive.
  logic [13:0] exp_addr_q[$];
  logic [13:0] exp_word_q[$];
  int planned_len = 0;
  int n_reads = 0;
  int n_words = 0;
  int n_done  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && !reset) begin
      if (ram_rd_en) begin
        chk("rd_during_wr", {31'd0, ram_wr_busy}, 32'd0);
        chk("credit", ((n_reads - n_words) < DEPTH) ? 32'd1 : 32'd0, 32'd1);
        if (exp_addr_q.size() == 0)
          chk("read_beyond_len", n_reads + 1, planned_len);
        else
          chk("rd_addr", {18'd0, ram_rd_addr}, {18'd0, exp_addr_q.pop_front()});
        n_reads++;
      end
      if (out_valid && out_ready) begin
        if (exp_word_q.size() == 0)
          chk("word_beyond_len", n_words + 1, planned_len);
        else
          chk("out_data", {16'd0, out_data}, {16'd0, mem_word(exp_word_q.pop_front())});
        n_words++;
      end
      if (done) n_done++;
    end
  end

  int ready_pct    = 100;
  int wr_pct       = 0;
  bit one_in_three = 1'b0;

  initial begin
    out_ready   = 1'b1;
    ram_wr_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready   = one_in_three ? (cyc % 3 == 0) : ($urandom_range(0, 99) < ready_pct);
      ram_wr_busy = ($urandom_range(0, 99) < wr_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_addr_q.delete();
    exp_word_q.delete();
    planned_len = 0;
    n_reads = 0;
    n_words = 0;
    n_done  = 0;
  endtask

  task automatic begin_transfer(input logic [13:0] b, input int len);
    logic [13:0] a;
    clear_model();
    planned_len = len;
    for (int i = 0; i < len; i++) begin
      a = b + i[13:0];
      exp_addr_q.push_back(a);
      exp_word_q.push_back(a);
    end
    base_addr = b;
    length    = len[14:0];
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", (n_done > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [13:0] base;
    int          len;
    int          rdy_pct;
    bit          rdy_1in3;
    int          wr_pct;
    int          exp_words;
    int          exp_done;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{14'h3FFE, 4, 100, 1'b0, 0, 4, 1};
    vecs[1] = '{14'h0123, 16, 0, 1'b1, 50, 16, 1};
    vecs[2] = '{14'h3FF0, 40, 10, 1'b0, 30, 40, 1};
    vecs[3] = '{14'h2000, 64, 100, 1'b0, 20, 64, 1};
    for (int i = 4; i < NV; i++) begin
      vecs[i].base      = 14'($urandom);
      vecs[i].len       = int'($urandom_range(1, 40));
      vecs[i].rdy_pct   = int'($urandom_range(20, 100));
      vecs[i].rdy_1in3  = 1'b0;
      vecs[i].wr_pct    = int'($urandom_range(0, 60));
      vecs[i].exp_words = vecs[i].len;
      vecs[i].exp_done  = 1;
    end

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
`ifdef SPRAM_READER_ABORT_EN
    abort     = 1'b0;
`endif
    #1;
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_rd_en",   {31'd0, ram_rd_en},   32'd0);
    chk("rst_rd_addr", {18'd0, ram_rd_addr}, 32'd0);
    chk("rst_valid",   {31'd0, out_valid},   32'd0);
    repeat (2) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Latency and sustained throughput.
    begin_transfer(14'h0010, 8);
    @(negedge clk);
    chk("lat_rd_en_c1", {31'd0, ram_rd_en}, 32'd1);
    chk("lat_valid_c1", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_valid_c2", {31'd0, out_valid}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stream_beat", {31'd0, out_valid}, 32'd1);
    end
    wait_done(100);
    chk("t1_words", n_words, 8);
    repeat (3) tick();
    chk("t1_done_once", n_done, 1);

    for (int i = 0; i < NV; i++) begin
      ready_pct    = vecs[i].rdy_pct;
      one_in_three = vecs[i].rdy_1in3;
      wr_pct       = vecs[i].wr_pct;
      tick();
      begin_transfer(vecs[i].base, vecs[i].len);
      wait_done(3000);
      chk("vec_words", n_words, vecs[i].exp_words);
      chk("vec_done", n_done, vecs[i].exp_done);
      chk("vec_leftover", exp_addr_q.size() + exp_word_q.size(), 0);
      repeat (3) tick();
      chk("vec_done_once", n_done, 1);
    end
    ready_pct    = 100;
    one_in_three = 1'b0;
    wr_pct       = 0;
    repeat (2) tick();

    // Zero-length transfer.
    begin_transfer(14'h0055, 0);
    @(negedge clk);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("len0_done_end", {31'd0, done}, 32'd0);
    chk("len0_busy_end", {31'd0, busy}, 32'd0);
    chk("len0_reads", n_reads, 0);
    tick();

    // Start pulses while busy must be ignored.
    begin_transfer(14'h0500, 5);
    base_addr = 14'h1111;
    length    = 15'd9;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick();
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(200);
    chk("busy_start_words", n_words, 5);
    chk("busy_start_reads", n_reads, 5);
    tick();

    // Reset in the middle of a transfer.
    begin_transfer(14'h0200, 10);
    for (int n = 0; n < 100 && n_words < 3; n++) tick();
    chk("mid_words_before_rst", (n_words >= 3) ? 32'd1 : 32'd0, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",    {31'd0, busy},        32'd0);
    chk("mid_rst_done",    {31'd0, done},        32'd0);
    chk("mid_rst_rd_en",   {31'd0, ram_rd_en},   32'd0);
    chk("mid_rst_rd_addr", {18'd0, ram_rd_addr}, 32'd0);
    chk("mid_rst_valid",   {31'd0, out_valid},   32'd0);
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    begin_transfer(14'h0700, 2);
    wait_done(100);
    chk("post_rst_words", n_words, 2);
    tick();

`ifdef SPRAM_READER_ABORT_EN
    // Abort with the FIFO full and the consumer stalled.
    ready_pct = 0;
    tick();
    begin_transfer(14'h0800, 12);
    repeat (8) tick();
    chk("abort_reads_pre", n_reads, DEPTH);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_done",  {31'd0, done},      32'd1);
    repeat (5) tick();
    chk("abort_no_reads", n_reads, DEPTH);
    chk("abort_done_once", n_done, 1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    ready_pct = 100;
    tick();
    begin_transfer(14'h0900, 3);
    wait_done(100);
    chk("post_abort_words", n_words, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
